// File: rtl/sbox_share_collect_if.sv
// Share-collector handshake bundle: bit-plane input side (in_*, y*, rnd)
// and byte-share output side (out_*, z*); master drives, slave collects.
interface sbox_share_collect_if;
  logic        in_valid;
  logic        in_ready;
  logic        y0;
  logic        y1;
  logic        y2;
  logic        y3;
  logic        y4;
  logic [31:0] rnd;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  z0;
  logic [7:0]  z1;
  logic [7:0]  z2;
  logic [7:0]  z3;
  logic [7:0]  z4;

  modport master (
    output in_valid,
    input  in_ready,
    output y0, y1, y2, y3, y4,
    output rnd,
    input  out_valid,
    output out_ready,
    input  z0, z1, z2, z3, z4
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  y0, y1, y2, y3, y4,
    input  rnd,
    output out_valid,
    input  out_ready,
    output z0, z1, z2, z3, z4
  );
endinterface

// File: rtl/sbox_share_collect.sv
// Packs 8 LSB-first bit planes of 5 shares into 5 byte shares.
// Ports: clk, rst (async high), clr (sync abort), bus (slave).
// Option: SHARE_REFRESH_EN re-shares the byte from bus.rnd.
module sbox_share_collect (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  sbox_share_collect_if.slave  bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [2:0]      cnt_q;
  logic [4:0][7:0] a_q;
  logic [4:0][7:0] p;
  logic [4:0][7:0] z_d;
  logic [4:0][7:0] z_q;
  logic [4:0]      y;
  logic            out_valid;
  logic            in_ready;
  logic            last;
  logic            accept;
  logic            done;

  assign y = {bus.y4, bus.y3, bus.y2,
              bus.y1, bus.y0};

  assign last      = (cnt_q == 3'd7);
  assign out_valid = (state_q == FULL);

  // Only the completing beat can stall,
  // and only behind an unconsumed byte.
  assign in_ready = ~last | ~out_valid
                  | bus.out_ready;

  // clr drops any beat in the same cycle.
  assign accept = bus.in_valid & in_ready
                & ~clr;
  assign done   = accept & last;

  always_comb begin
    for (int i = 0; i < 5; i++) begin
      p[i] = {y[i], a_q[i][7:1]};
    end
  end

`ifdef SHARE_REFRESH_EN
  logic [7:0] r0;
  logic [7:0] r1;
  logic [7:0] r2;
  logic [7:0] r3;

  assign r0 = bus.rnd[7:0];
  assign r1 = bus.rnd[15:8];
  assign r2 = bus.rnd[23:16];
  assign r3 = bus.rnd[31:24];

  // Each r_k enters two neighbouring shares,
  // so the XOR of all five is unchanged.
  assign z_d[0] = p[0] ^ r0;
  assign z_d[1] = p[1] ^ r0 ^ r1;
  assign z_d[2] = p[2] ^ r1 ^ r2;
  assign z_d[3] = p[3] ^ r2 ^ r3;
  assign z_d[4] = p[4] ^ r3;
`else
  logic unused_rnd;

  assign unused_rnd = ^bus.rnd;
  assign z_d        = p;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 3'd0;
      a_q   <= '0;
    end else if (clr) begin
      cnt_q <= 3'd0;
      a_q   <= '0;
    end else if (accept) begin
      cnt_q <= cnt_q + 3'd1;
      a_q   <= p;
    end
  end

  // Accumulators stay dirty after a byte;
  // the next eight beats overwrite them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z_q <= '0;
    end else if (done) begin
      z_q <= z_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: begin
        if (done) begin
          state_d = FULL;
        end
      end
      FULL: begin
        if (done) begin
          state_d = FULL;
        end else if (bus.out_ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.z0        = z_q[0];
  assign bus.z1        = z_q[1];
  assign bus.z2        = z_q[2];
  assign bus.z3        = z_q[3];
  assign bus.z4        = z_q[4];

endmodule

// File: tb/tb_sbox_share_collect.sv
// Directed and random bench for sbox_share_collect.
// Expected values follow SHARE_REFRESH_EN when it is defined.
module tb_sbox_share_collect;

  logic clk;
  logic rst;
  logic clr;

  sbox_share_collect_if bus ();

  sbox_share_collect u_dut (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  p [5];
    logic [31:0] rnd;
    logic [7:0]  z [5];
  } vec_t;

  vec_t vecs [4];
  int   n_cmp;
  int   n_err;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h",
               name, act, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v,
                       input logic [4:0] y,
                       input logic [31:0] r);
    bus.in_valid = v;
    bus.y0 = y[0];
    bus.y1 = y[1];
    bus.y2 = y[2];
    bus.y3 = y[3];
    bus.y4 = y[4];
    bus.rnd = r;
    #1;
  endtask

  task automatic do_reset;
    drive(1'b0, 5'd0, 32'd0);
    bus.out_ready = 1'b1;
    clr = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
  endtask

  function automatic logic [7:0] zx;
    return bus.z0 ^ bus.z1 ^ bus.z2
         ^ bus.z3 ^ bus.z4;
  endfunction

  // y0 plane for bit b of byte v, all other shares 0
  function automatic logic [4:0] pl0(
      input logic [7:0] v, input int b);
    return {4'd0, v[b]};
  endfunction

  initial begin
    logic [4:0]  yv;
    logic [7:0]  m_acc;
    logic [7:0]  q [$];
    int          m_cnt;
    int          got;
    int          cycles;
    logic        acc;
    logic        cons;
    logic        eir;

    n_cmp = 0;
    n_err = 0;

    vecs[0].p   = '{8'h85, 8'h00, 8'h00,
                    8'h00, 8'h00};
    vecs[0].rnd = 32'h0;
    vecs[0].z   = '{8'h85, 8'h00, 8'h00,
                    8'h00, 8'h00};
    vecs[1].p   = '{8'hA5, 8'h3C, 8'hFF,
                    8'h00, 8'h5A};
    vecs[1].rnd = 32'h0;
    vecs[1].z   = '{8'hA5, 8'h3C, 8'hFF,
                    8'h00, 8'h5A};
    vecs[2].p   = '{8'h3C, 8'h00, 8'h00,
                    8'h00, 8'h00};
    vecs[2].rnd = 32'hA5A5_5A5A;
`ifdef SHARE_REFRESH_EN
    vecs[2].z   = '{8'h66, 8'h00, 8'hFF,
                    8'h00, 8'hA5};
`else
    vecs[2].z   = '{8'h3C, 8'h00, 8'h00,
                    8'h00, 8'h00};
`endif
    vecs[3].p   = '{8'h01, 8'h02, 8'h04,
                    8'h80, 8'hFE};
    vecs[3].rnd = 32'h0;
    vecs[3].z   = '{8'h01, 8'h02, 8'h04,
                    8'h80, 8'hFE};

    // reset values
    rst = 1'b0;
    clr = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 5'd0, 32'd0);
    rst = 1'b1;
    #6;
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_z_or", 32'(bus.z0 | bus.z1 | bus.z2
                        | bus.z3 | bus.z4), 0);
    cyc();
    rst = 1'b0;
    bus.out_ready = 1'b1;

    // table vectors, out_ready held high
    for (int v = 0; v < 4; v++) begin
      for (int b = 0; b < 8; b++) begin
        for (int i = 0; i < 5; i++)
          yv[i] = vecs[v].p[i][b];
        drive(1'b1, yv, (b == 7) ? vecs[v].rnd
                                 : 32'hDEAD_BEEF);
        chk($sformatf("v%0d_ir%0d", v, b),
            32'(bus.in_ready), 1);
        cyc();
        if (b == 6)
          chk($sformatf("v%0d_early", v),
              32'(bus.out_valid), 0);
      end
      drive(1'b0, 5'd0, 32'd0);
      chk($sformatf("v%0d_ov", v),
          32'(bus.out_valid), 1);
      chk($sformatf("v%0d_z0", v), 32'(bus.z0),
          32'(vecs[v].z[0]));
      chk($sformatf("v%0d_z1", v), 32'(bus.z1),
          32'(vecs[v].z[1]));
      chk($sformatf("v%0d_z2", v), 32'(bus.z2),
          32'(vecs[v].z[2]));
      chk($sformatf("v%0d_z3", v), 32'(bus.z3),
          32'(vecs[v].z[3]));
      chk($sformatf("v%0d_z4", v), 32'(bus.z4),
          32'(vecs[v].z[4]));
      chk($sformatf("v%0d_zx", v), 32'(zx()),
          32'(vecs[v].p[0] ^ vecs[v].p[1]
              ^ vecs[v].p[2] ^ vecs[v].p[3]
              ^ vecs[v].p[4]));
      cyc();
      chk($sformatf("v%0d_one", v),
          32'(bus.out_valid), 0);
    end

    // backpressure: 16 beats, out_ready low
    do_reset();
    bus.out_ready = 1'b0;
    for (int b = 0; b < 16; b++) begin
      drive(1'b1, (b < 8) ? pl0(8'h96, b)
                          : pl0(8'h4B, b - 8),
            32'd0);
      chk($sformatf("bp_ir%0d", b),
          32'(bus.in_ready), (b == 15) ? 0 : 1);
      cyc();
      if (b >= 7) begin
        chk($sformatf("bp_ov%0d", b),
            32'(bus.out_valid), 1);
        chk($sformatf("bp_hold%0d", b),
            32'(bus.z0), 32'h96);
      end
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_ir_rel", 32'(bus.in_ready), 1);
    cyc();
    drive(1'b0, 5'd0, 32'd0);
    chk("bp_ov2", 32'(bus.out_valid), 1);
    chk("bp_z2", 32'(bus.z0), 32'h4B);
    cyc();
    chk("bp_empty", 32'(bus.out_valid), 0);

    // abort: 5 beats, clr with a beat, 8 ones
    do_reset();
    for (int b = 0; b < 5; b++) begin
      drive(1'b1, 5'd0, 32'd0);
      cyc();
    end
    clr = 1'b1;
    drive(1'b1, 5'h1F, 32'd0);
    cyc();
    clr = 1'b0;
    for (int b = 0; b < 8; b++) begin
      drive(1'b1, 5'h1F, 32'd0);
      cyc();
      if (b == 6)
        chk("clr_early", 32'(bus.out_valid), 0);
    end
    drive(1'b0, 5'd0, 32'd0);
    chk("clr_ov", 32'(bus.out_valid), 1);
    chk("clr_z0", 32'(bus.z0), 32'hFF);
    chk("clr_z1", 32'(bus.z1), 32'hFF);
    chk("clr_z2", 32'(bus.z2), 32'hFF);
    chk("clr_z3", 32'(bus.z3), 32'hFF);
    chk("clr_z4", 32'(bus.z4), 32'hFF);
    cyc();

    // async reset while FULL and mid-byte
    do_reset();
    bus.out_ready = 1'b0;
    for (int b = 0; b < 11; b++) begin
      drive(1'b1, pl0(8'hC3, b % 8), 32'd0);
      cyc();
    end
    drive(1'b0, 5'd0, 32'd0);
    chk("ar_pend", 32'(bus.z0), 32'hC3);
    #1;
    rst = 1'b1;
    #1;
    chk("ar_ov", 32'(bus.out_valid), 0);
    chk("ar_z0", 32'(bus.z0), 0);
    chk("ar_ir", 32'(bus.in_ready), 1);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int b = 0; b < 8; b++) begin
      drive(1'b1, pl0(8'h5A, b), 32'd0);
      cyc();
      if (b == 6)
        chk("ar_early", 32'(bus.out_valid), 0);
    end
    drive(1'b0, 5'd0, 32'd0);
    chk("ar_ov2", 32'(bus.out_valid), 1);
    chk("ar_z", 32'(bus.z0), 32'h5A);
    cyc();

    // random gaps, XOR scoreboard
    do_reset();
    m_acc  = 8'h00;
    m_cnt  = 0;
    got    = 0;
    cycles = 0;
    while (got < 1000 && cycles < 60000) begin
      yv = 5'($urandom);
      bus.out_ready =
        ($urandom_range(0, 9) < 6);
      drive(($urandom_range(0, 9) < 7), yv,
            $urandom);
      eir = (m_cnt != 7) || (q.size() == 0)
            || bus.out_ready;
      chk("rnd_ir", 32'(bus.in_ready),
          32'(eir));
      chk("rnd_ov", 32'(bus.out_valid),
          32'(q.size() != 0));
      acc  = bus.in_valid && eir;
      cons = (q.size() != 0) && bus.out_ready;
      if (cons) begin
        chk($sformatf("rnd_byte%0d", got),
            32'(zx()), 32'(q[0]));
        void'(q.pop_front());
        got++;
      end
      if (acc) begin
        m_acc = {^yv, m_acc[7:1]};
        if (m_cnt == 7) begin
          q.push_back(m_acc);
          m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end
      cyc();
      cycles++;
    end
    chk("rnd_count", 32'(got), 1000);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sbox_share_collect.md
# sbox_share_collect

Output-side companion to the masked S-box table-recomputation pipeline. It receives the five 1-bit output shares produced by the lookup stage, one bit plane per accepted beat, and packs eight consecutive beats into five 8-bit byte shares. It then presents the byte shares to the downstream masked round logic through a valid/ready handshake. Shares are never XOR-combined internally. The unmasked value exists only as the XOR of the five outputs.

## Interface
- No parameters. Share count is fixed at 5 and byte width at 8.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `clr`  input  1  synchronous abort. Discards the partially collected byte.
- `in_valid`  input  1  `y0..y4` carry a valid bit plane.
- `in_ready`  output  1  collector accepts a beat this cycle.
- `y0`, `y1`, `y2`, `y3`, `y4`  input  1 each  output shares of the lookup stage for one bit position.
- `rnd`  input  32  fresh randomness; only bits [31:0] are used, and only when re-sharing is compiled in.
- `out_valid`  output  1  `z0..z4` hold a complete byte.
- `out_ready`  input  1  downstream consumes the byte.
- `z0`, `z1`, `z2`, `z3`, `z4`  output  8 each  byte shares.

## Operation
- Accumulators `a0..a4` are 8 bits each.
- The bit counter `cnt` is 3 bits and counts beats accepted in the current byte, 0..7.
- A beat is accepted when `in_valid && in_ready`. On acceptance, each `a_i <= {y_i, a_i[7:1]}`, so the first accepted beat lands in bit 0 (LSB first).
- The counter increments on acceptance and wraps from 7 to 0.
- Output register states:
  - EMPTY: `out_valid` = 0.
  - FULL: `out_valid` = 1.
- The beat with `cnt == 7` completes the byte:
  - The packed values `{y_i, a_i[7:1]}` are loaded into `z_i`.
  - The state becomes FULL.
  - `cnt` returns to 0.
  - The accumulators are left dirty; they are fully overwritten by the next eight beats.
- `in_ready` = `(cnt != 7) | ~out_valid | out_ready`:
  - Beats 0..6 are always accepted, even while FULL.
  - Only the completing beat stalls, and only behind an unconsumed output.
- FULL → EMPTY when `out_ready` is high and no completing beat is accepted in the same cycle.
- If a completing beat is accepted in the same cycle as `out_ready`, the new byte is loaded and the state stays FULL (back-to-back, no bubble).
- `z0..z4` are stable while `out_valid && !out_ready`.
- `clr`:
  - Forces `cnt` to 0 and `a0..a4` to 0.
  - Any beat presented in the same cycle is dropped; `clr` wins over `in_valid`.
  - It does not affect the output register: a pending FULL byte remains and is consumed normally.
- Sharing invariant: XOR of `z0..z4` equals the XOR of `{y_i}` packed over the byte.

## Timing
- Reset values:
  - `in_ready` = 1.
  - `out_valid` = 0.
  - `z0..z4` = 8'h00.
  - `cnt` = 0.
  - `a0..a4` = 0.
- Latency: if the 8th beat is accepted at edge k, `out_valid` is high in the cycle following edge k.
- Throughput: one byte per 8 accepted beats, with no dead cycles when `out_ready` is held high.
- `in_ready` is combinational from `cnt`, `out_valid` and `out_ready`. It has no dependence on `in_valid`.
- Reset asserted mid-byte or while FULL: all state clears immediately. Partial and pending bytes are lost.

## Configuration
- `SHARE_REFRESH_EN` defined: the five shares are refreshed from `rnd` at byte completion. With `r0..r3` = `rnd[7:0]`, `[15:8]`, `[23:16]`, `[31:24]`:
  - `z0 = p0^r0`
  - `z1 = p1^r0^r1`
  - `z2 = p2^r1^r2`
  - `z3 = p3^r2^r3`
  - `z4 = p4^r3`
  - Here `p_i` are the packed bytes. `rnd` is sampled only on the completing beat.
- Macro undefined: `z_i = p_i` and `rnd` is ignored. No other behaviour changes.

## Test plan
- Basic pack, LSB first: after reset, 8 beats with `out_ready` = 1, `y0` = 1,0,1,0,0,0,0,1 and `y1..y4` = 0 → `z0` = 8'h85, `z1..z4` = 0, `out_valid` high for exactly one cycle, one cycle after the 8th beat.
- Backpressure: hold `out_ready` = 0 and stream 16 beats with `in_valid` = 1 → the first byte is held stable, beats 9..15 are accepted, beat 16 stalls (`in_ready` = 0). Raise `out_ready` → first byte consumed and beat 16 accepted in the same cycle, second byte valid the next cycle.
- Abort: 5 beats, then `clr` together with `in_valid` = 1, then 8 beats of all-ones on `y0..y4` → all of `z0..z4` = 8'hFF. The clr-cycle beat is not counted.
- Async reset mid-byte: assert `rst` between edges after 3 beats → `out_valid`, `cnt` and the outputs are 0 immediately, and the next 8 beats form a fresh byte.
- Re-sharing (`SHARE_REFRESH_EN`): `y0` packs to 8'h3C, other shares 0, `rnd` = 32'hA5A5_5A5A on the 8th beat → `z0` = 8'h66, and the XOR of `z0..z4` = 8'h3C. Without the macro, `z0` = 8'h3C.
- Randomised: 1000 bytes with random valid/ready gaps → the XOR of `z0..z4` matches a reference model packing of the `y` XOR, in order, with no loss or duplication.
